pattern_sequencer: RTL and testbench

PATTERN_SEQUENCER -- requirements
Module: pattern_sequencer

---
 rtl/pattern_sequencer.sv | 122 ++++++++++++
 tb/tb_pattern_sequencer.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/pattern_sequencer.sv
// Serial pattern driver for a two-output detector: shifts a captured
// pattern out LSB first, drains, then reports per-run z1/z2 hit counts.
module pattern_sequencer #(
   parameter int PAT_WIDTH = 16,
   parameter int LEN_W     = 5,
   parameter int CNT_WIDTH = 8,
   parameter int DRAIN_CYC = 2
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 start,
   input  logic                 abort,
   input  logic [PAT_WIDTH-1:0] pattern,
   input  logic [LEN_W-1:0]     len,
   input  logic                 z1,
   input  logic                 z2,
   output logic                 a,
   output logic                 busy,
   output logic                 done,
   output logic [CNT_WIDTH-1:0] z1_count,
   output logic [CNT_WIDTH-1:0] z2_count
);

   localparam int RW = $clog2(PAT_WIDTH + 1);
   localparam int DW = (DRAIN_CYC > 1) ? $clog2(DRAIN_CYC) : 1;

   typedef enum logic [1:0] {IDLE, SHIFT, DRAIN, DONE} state_t;

   state_t               state;
   logic [PAT_WIDTH-1:0] shreg;
   logic [RW-1:0]        remain;
   logic [DW-1:0]        drain_cnt;
   logic [RW-1:0]        eff_len;

   always_comb begin
      eff_len = RW'(len);
      if (32'(len) > PAT_WIDTH) eff_len = RW'(PAT_WIDTH);
   end

   function automatic logic [CNT_WIDTH-1:0] bump(
      input logic [CNT_WIDTH-1:0] c,
      input logic                 z
   );
      return (z && (c != '1)) ? c + 1'b1 : c;
   endfunction

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         shreg     <= '0;
         remain    <= '0;
         drain_cnt <= '0;
         a         <= 1'b0;
         busy      <= 1'b0;
         done      <= 1'b0;
         z1_count  <= '0;
         z2_count  <= '0;
      end else begin
         done <= 1'b0;
         // The sample at an aborting edge still counts, so it sits outside the case.
         if (state == SHIFT || state == DRAIN) begin
            z1_count <= bump(z1_count, z1);
            z2_count <= bump(z2_count, z2);
         end
         unique case (state)
            IDLE: begin
               if (start) begin
                  z1_count <= '0;
                  z2_count <= '0;
                  shreg    <= pattern >> 1;
                  if (eff_len == '0) begin
                     remain <= '0;
                     state  <= DONE;
                     done   <= 1'b1;
                  end else begin
                     remain <= eff_len - 1'b1;
                     a      <= pattern[0];
                     busy   <= 1'b1;
                     state  <= SHIFT;
                  end
               end
            end
            SHIFT: begin
               if (abort) begin
                  state <= IDLE;
                  a     <= 1'b0;
                  busy  <= 1'b0;
               end else if (remain == '0) begin
                  a <= 1'b0;
                  if (DRAIN_CYC == 0) begin
                     state <= DONE;
                     done  <= 1'b1;
                     busy  <= 1'b0;
                  end else begin
                     state     <= DRAIN;
                     drain_cnt <= DW'(DRAIN_CYC - 1);
                  end
               end else begin
                  a      <= shreg[0];
                  shreg  <= shreg >> 1;
                  remain <= remain - 1'b1;
               end
            end
            DRAIN: begin
               if (abort) begin
                  state <= IDLE;
                  busy  <= 1'b0;
               end else if (drain_cnt == '0) begin
                  state <= DONE;
                  done  <= 1'b1;
                  busy  <= 1'b0;
               end else begin
                  drain_cnt <= drain_cnt - 1'b1;
               end
            end
            DONE: state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_pattern_sequencer.sv
// Bench for pattern_sequencer: directed scenarios plus randomized runs
// checked against a cycle-indexed model of the serial protocol.
module tb_pattern_sequencer;

   logic        clk = 1'b0;
   logic        rst_n = 1'b1;
   logic        start = 1'b0;
   logic        abort = 1'b0;
   logic [15:0] pattern = '0;
   logic [4:0]  len = '0;
   logic        z1, z2;
   logic        z1_r = 1'b0;
   logic        z2_r = 1'b0;
   bit          loop_mode = 1'b1;
   logic        a, busy, done;
   logic [7:0]  z1_count, z2_count;
   logic        s_a, s_busy, s_done;
   logic [1:0]  s_z1_count, s_z2_count;

   int checks = 0;
   int errors = 0;
   int exp_z1 = 0;
   int exp_z2 = 0;

   assign z1 = loop_mode ? a : z1_r;
   assign z2 = loop_mode ? ~a : z2_r;

   always #5 clk = ~clk;

   pattern_sequencer dut (
      .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
      .pattern(pattern), .len(len), .z1(z1), .z2(z2),
      .a(a), .busy(busy), .done(done),
      .z1_count(z1_count), .z2_count(z2_count)
   );

   pattern_sequencer #(.CNT_WIDTH(2)) sat (
      .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
      .pattern(pattern), .len(len), .z1(1'b1), .z2(~s_a),
      .a(s_a), .busy(s_busy), .done(s_done),
      .z1_count(s_z1_count), .z2_count(s_z2_count)
   );

   // One run: expected a/busy/done at cycle k after the accept edge follow
   // directly from the effective length; counts from the sampled z values.
   task automatic do_run(input logic [15:0] pat, input int ln,
                         input bit loop, input int ab_k, input int rs_k,
                         input bit ab_start, input bit rel,
                         input string name);
      int L, dn, kend, nsamp, e1, e2;
      logic ea, eb, ed, zz1, zz2;
      bit aborted;
      L = (ln > 16) ? 16 : ln;
      dn = (L == 0) ? 0 : L + 2;
      kend = dn + 2;
      nsamp = 0; e1 = 0; e2 = 0; aborted = 0;
      @(negedge clk);
      loop_mode = loop;
      if (rel) rst_n = 1'b1;
      start = 1'b1;
      abort = ab_start;
      pattern = pat;
      len = 5'(ln);
      @(posedge clk); #1;
      start = 1'b0;
      abort = 1'b0;
      pattern = 16'($urandom);
      len = 5'($urandom);
      for (int k = 0; k <= kend; k++) begin
         if (aborted) begin
            ea = 0; eb = 0; ed = 0;
         end else begin
            ea = (k < L) ? pat[k] : 1'b0;
            eb = (L > 0) && (k < L + 2);
            ed = (k == dn);
         end
         checks++;
         if ({a, busy, done} !== {ea, eb, ed}) begin
            errors++;
            $display("FAIL %s k=%0d a/busy/done got %b%b%b expected %b%b%b",
                     name, k, a, busy, done, ea, eb, ed);
         end
         checks++;
         if ({s_busy, s_done} !== {eb, ed}) begin
            errors++;
            $display("FAIL %s sat k=%0d busy/done got %b%b expected %b%b",
                     name, k, s_busy, s_done, eb, ed);
         end
         @(negedge clk);
         zz1 = loop ? ea : 1'($urandom);
         zz2 = loop ? ~ea : 1'($urandom);
         z1_r = zz1;
         z2_r = zz2;
         if (eb) begin
            nsamp++;
            e1 += int'(zz1);
            e2 += int'(zz2);
         end
         if (k == ab_k) abort = 1'b1;
         if (k == rs_k) begin
            start = 1'b1;
            pattern = 16'h5555;
            len = 5'd3;
         end
         @(posedge clk); #1;
         abort = 1'b0;
         start = 1'b0;
         if (k == ab_k) aborted = 1;
      end
      exp_z1 = (e1 > 255) ? 255 : e1;
      exp_z2 = (e2 > 255) ? 255 : e2;
      checks++;
      if ({z1_count, z2_count} !== {8'(exp_z1), 8'(exp_z2)}) begin
         errors++;
         $display("FAIL %s counts got %0d/%0d expected %0d/%0d",
                  name, z1_count, z2_count, exp_z1, exp_z2);
      end
      checks++;
      if (s_z1_count !== 2'((nsamp > 3) ? 3 : nsamp)) begin
         errors++;
         $display("FAIL %s sat z1_count got %0d expected %0d",
                  name, s_z1_count, (nsamp > 3) ? 3 : nsamp);
      end
   endtask

   task automatic check_all_zero(input string name);
      checks++;
      if ({a, busy, done, z1_count, z2_count,
           s_a, s_busy, s_done, s_z1_count, s_z2_count} !== '0) begin
         errors++;
         $display("FAIL %s outputs got %b%b%b %0d %0d sat %b%b%b %0d %0d expected all 0",
                  name, a, busy, done, z1_count, z2_count,
                  s_a, s_busy, s_done, s_z1_count, s_z2_count);
      end
   endtask

   task automatic test_reset();
      #2 rst_n = 1'b0;
      #1 check_all_zero("reset_async");
      repeat (3) @(posedge clk);
      #1 check_all_zero("reset_held");
   endtask

   task automatic test_scenario1();
      do_run(16'h000B, 4, 1, -1, -1, 0, 1, "scn1");
   endtask

   task automatic test_len0();
      do_run(16'($urandom), 0, 1, -1, -1, 0, 0, "len0");
   endtask

   task automatic test_saturation();
      do_run(16'($urandom), 16, 1, -1, -1, 0, 0, "sat16");
   endtask

   task automatic test_abort();
      do_run(16'($urandom), 8, 1, 2, -1, 0, 0, "abort");
      do_run(16'($urandom), 5, 0, 6, -1, 0, 0, "abort_drain");
   endtask

   task automatic test_reset_mid_run();
      @(negedge clk);
      loop_mode = 1'b1;
      start = 1'b1;
      pattern = 16'hFFFF;
      len = 5'd10;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (3) @(posedge clk);
      #2 rst_n = 1'b0;
      #1 check_all_zero("reset_mid");
      do_run(16'($urandom), 7, 1, -1, -1, 0, 1, "after_reset");
   endtask

   task automatic test_clamp_restart();
      do_run(16'hFFFF, 20, 1, -1, 3, 0, 0, "clamp_restart");
      do_run(16'($urandom), 18, 0, -1, 17, 0, 0, "restart_done");
   endtask

   task automatic test_idle_abort();
      int h1, h2;
      h1 = exp_z1;
      h2 = exp_z2;
      @(negedge clk);
      abort = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      checks++;
      if ({a, busy, done} !== 3'b000 || z1_count !== 8'(h1) || z2_count !== 8'(h2)) begin
         errors++;
         $display("FAIL idle_abort got %b%b%b %0d/%0d expected 000 %0d/%0d",
                  a, busy, done, z1_count, z2_count, h1, h2);
      end
      abort = 1'b0;
   endtask

   task automatic test_start_abort();
      do_run(16'($urandom), 6, 1, -1, -1, 1, 0, "start_abort");
   endtask

   task automatic test_random();
      int ln, abk;
      for (int i = 0; i < 40; i++) begin
         ln = $urandom_range(0, 20);
         abk = -1;
         if (ln > 0 && $urandom_range(0, 3) == 0)
            abk = $urandom_range(0, ((ln > 16) ? 16 : ln) + 1);
         do_run(16'($urandom), ln, 1'($urandom), abk, -1, 0, 0, "random");
      end
   endtask

   initial begin
      test_reset();
      test_scenario1();
      test_len0();
      test_saturation();
      test_abort();
      test_reset_mid_run();
      test_clamp_restart();
      test_idle_abort();
      test_start_abort();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
